// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: routes the init, auto-refresh, write and read engines
// onto the SDRAM pins, one engine at a time, with refresh > write > read
// priority, a write-streak limit that keeps reads from starving, and a grant
// watchdog that recovers from an engine that never finishes.
module sdram_arbiter #(
    parameter int MAX_WR_STREAK = 4,
    parameter int TIMEOUT_CYC   = 1023
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic        wr_dq_oe,
    input  logic [15:0] wr_dq,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic        sdram_dq_oe,
    output logic [15:0] sdram_dq_out,
    output logic        arb_timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    localparam logic [3:0] CMD_NOP    = 4'b0111;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_WR_STREAK);
    // Counter holds the number of granted cycles already completed, so the
    // grant expires at the end of granted cycle number TIMEOUT_CYC.
    localparam logic [9:0] WDOG_LAST  = 10'(TIMEOUT_CYC - 1);

    state_t      r_state;
    logic [3:0]  r_wr_streak;
    logic [9:0]  r_wdog;
    logic        r_timeout;

    logic        w_end;
    logic        w_expire;
    logic [3:0]  w_cmd;

    // End pulse of the engine currently granted; other engines' pulses ignored
    always_comb begin
        w_end = 1'b0;
        case (r_state)
            AREF:    w_end = aref_end;
            WRITE:   w_end = wr_end;
            READ:    w_end = rd_end;
            default: w_end = 1'b0;
        endcase
    end

    // A completion on the expiry cycle wins over the watchdog
    assign w_expire = ((r_state == AREF) || (r_state == WRITE) || (r_state == READ))
                      && !w_end && (r_wdog == WDOG_LAST);

    // Arbitration FSM with write-streak and watchdog bookkeeping
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            r_state     <= IDLE;
            r_wr_streak <= 4'd0;
            r_wdog      <= 10'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (init_end) r_state <= ARBIT;
                end
                ARBIT: begin
                    r_wdog <= 10'd0;
                    if (aref_req) begin
                        r_state <= AREF;
                    end else if (rd_req && (r_wr_streak == STREAK_MAX)) begin
                        r_state     <= READ;
                        r_wr_streak <= 4'd0;
                    end else if (wr_req) begin
                        r_state <= WRITE;
                        if (!rd_req)
                            r_wr_streak <= 4'd0;
                        else if (r_wr_streak != STREAK_MAX)
                            r_wr_streak <= r_wr_streak + 4'd1;
                    end else if (rd_req) begin
                        r_state     <= READ;
                        r_wr_streak <= 4'd0;
                    end
                end
                AREF, WRITE, READ: begin
                    if (w_end) begin
                        r_state <= ARBIT;
                    end else if (w_expire) begin
                        r_state   <= ARBIT;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 10'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pin mux: owner's bus in granted/IDLE states, NOP otherwise
    always_comb begin
        w_cmd        = CMD_NOP;
        sdram_ba     = 2'd0;
        sdram_addr   = 13'd0;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = 16'd0;
        case (r_state)
            IDLE: begin
                w_cmd      = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            AREF: begin
                w_cmd      = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                w_cmd        = wr_cmd;
                sdram_ba     = wr_ba;
                sdram_addr   = wr_addr;
                sdram_dq_oe  = wr_dq_oe;
                sdram_dq_out = wr_dq;
            end
            READ: begin
                w_cmd      = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
    assign sdram_cke   = 1'b1;
    assign aref_en     = (r_state == AREF);
    assign wr_en       = (r_state == WRITE);
    assign rd_en       = (r_state == READ);
    assign arb_timeout = r_timeout;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised and directed bench for sdram_arbiter. A transaction-level model
// tracks which engine owns the bus; each cycle the expected pin/grant picture
// is queued and a negedge monitor compares it with the DUT.
module tb_sdram_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_dq_oe;
    logic [15:0] wr_dq;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en, cke;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        arb_timeout;

    always #5 clk = ~clk;

    sdram_arbiter #(.MAX_WR_STREAK(MAXS), .TIMEOUT_CYC(TMO)) dut (
        .sdram_clk(clk), .sdram_rst(rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end),
        .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end),
        .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_dq_oe(wr_dq_oe), .wr_dq(wr_dq),
        .rd_req(rd_req), .rd_end(rd_end),
        .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(cke),
        .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .sdram_ba(ba), .sdram_addr(addr), .sdram_dq_oe(dq_oe), .sdram_dq_out(dq_out),
        .arb_timeout(arb_timeout)
    );

    // Bus owner as seen by the model
    typedef enum {M_IDLE, M_ARB, M_AREF, M_WR, M_RD} own_t;
    own_t m_own;
    int   m_streak;   // writes granted back-to-back while a read was waiting
    int   m_age;      // granted cycles completed by the current owner
    bit   m_to;       // watchdog fired at the last edge

    typedef struct {
        logic [2:0]  gnt;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        oe;
        logic [15:0] dq;
        logic        to;
    } exp_t;
    exp_t sbq[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit fix_dq = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("grant",   32'({aref_en, wr_en, rd_en}), 32'(e.gnt));
                chk("cmd",     32'({cs_n, ras_n, cas_n, we_n}), 32'(e.cmd));
                chk("ba_addr", 32'({ba, addr}), 32'({e.ba, e.addr}));
                chk("dq",      32'({dq_oe, dq_out}), 32'({e.oe, e.dq}));
                chk("timeout", 32'(arb_timeout), 32'(e.to));
                chk("cke",     32'(cke), 32'd1);
            end
        end
    end

    // Advance the model by one clock using the inputs the DUT just sampled
    task automatic model_update();
        bit e;
        bit to_n;
        to_n = 1'b0;
        if (rst) begin
            m_own = M_IDLE; m_streak = 0; m_age = 0;
        end else begin
            case (m_own)
                M_IDLE: if (init_end) m_own = M_ARB;
                M_ARB: begin
                    m_age = 0;
                    if (aref_req) m_own = M_AREF;
                    else if (rd_req && m_streak >= MAXS) begin m_own = M_RD; m_streak = 0; end
                    else if (wr_req) begin
                        m_own = M_WR;
                        m_streak = rd_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
                    end
                    else if (rd_req) begin m_own = M_RD; m_streak = 0; end
                end
                default: begin
                    e = (m_own == M_AREF) ? aref_end : (m_own == M_WR) ? wr_end : rd_end;
                    m_age++;
                    if (e) m_own = M_ARB;
                    else if (m_age >= TMO) begin m_own = M_ARB; to_n = 1'b1; end
                end
            endcase
        end
        m_to = to_n;
    endtask

    task automatic push_exp();
        exp_t e;
        e.gnt = {m_own == M_AREF, m_own == M_WR, m_own == M_RD};
        e.cmd = 4'b0111; e.ba = 2'd0; e.addr = 13'd0; e.oe = 1'b0; e.dq = 16'd0;
        e.to  = m_to;
        case (m_own)
            M_IDLE: begin e.cmd = init_cmd; e.ba = init_ba; e.addr = init_addr; end
            M_AREF: begin e.cmd = aref_cmd; e.ba = aref_ba; e.addr = aref_addr; end
            M_WR: begin
                e.cmd = wr_cmd; e.ba = wr_ba; e.addr = wr_addr;
                e.oe = wr_dq_oe; e.dq = wr_dq;
            end
            M_RD:   begin e.cmd = rd_cmd; e.ba = rd_ba; e.addr = rd_addr; end
            default: ;
        endcase
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic drive_cycle();
        push_exp();
        tick();
    endtask

    task automatic rand_bus();
        aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = 13'($urandom);
        wr_cmd   = 4'($urandom); wr_ba   = 2'($urandom); wr_addr   = 13'($urandom);
        rd_cmd   = 4'($urandom); rd_ba   = 2'($urandom); rd_addr   = 13'($urandom);
        if (fix_dq) begin wr_dq_oe = 1'b1; wr_dq = 16'hA5A5; end
        else begin wr_dq_oe = 1'($urandom); wr_dq = 16'($urandom); end
    endtask

    // Engines complete on granted cycle end_at+1 (never when end_at < 0);
    // rnd mode randomises requests, ends and occasional resets.
    task automatic run(int n, int end_at, bit rnd);
        for (int i = 0; i < n; i++) begin
            aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
            if (rnd) begin
                rst = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 7) == 0) aref_req = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) wr_req = 1'($urandom);
                if ($urandom_range(0, 7) == 0) rd_req = 1'($urandom);
                aref_end = ($urandom_range(0, 9) == 0);
                wr_end   = ($urandom_range(0, 9) == 0);
                rd_end   = ($urandom_range(0, 9) == 0);
                case (m_own)
                    M_AREF: aref_end = ($urandom_range(0, 5) == 0);
                    M_WR:   wr_end   = ($urandom_range(0, 5) == 0);
                    M_RD:   rd_end   = ($urandom_range(0, 5) == 0);
                    default: ;
                endcase
            end else if (end_at >= 0 && m_age == end_at) begin
                case (m_own)
                    M_AREF: aref_end = 1'b1;
                    M_WR:   wr_end   = 1'b1;
                    M_RD:   rd_end   = 1'b1;
                    default: ;
                endcase
            end
            rand_bus();
            drive_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; init_end = 1'b0;
        init_cmd = 4'b0111; init_ba = 2'd0; init_addr = 13'd0;
        aref_req = 1'b0; aref_end = 1'b0; wr_req = 1'b0; wr_end = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0;
        rand_bus();
        tick();
        // second reset cycle, then init bus passthrough while init_end=0
        drive_cycle();
        rst = 1'b0;
        init_cmd = 4'b0010; init_ba = 2'd1; init_addr = 13'h0ABC;
        run(3, -1, 1'b0);
        init_end = 1'b1;
        run(1, -1, 1'b0);
        init_cmd = 4'b0111; init_ba = 2'd0; init_addr = 13'd0;
        run(2, -1, 1'b0);
        // priority: all three requests together
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        run(2, -1, 1'b0);
        aref_req = 1'b0; rd_req = 1'b0;
        run(8, 2, 1'b0);
        // write-streak limit with fixed write data
        fix_dq = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1;
        run(70, 7, 1'b0);
        // watchdog: read never completes, then completes on the expiry cycle
        wr_req = 1'b0;
        run(3, -1, 1'b0);
        rd_req = 1'b0;
        run(20, -1, 1'b0);
        rd_req = 1'b1;
        run(2, -1, 1'b0);
        rd_req = 1'b0;
        run(18, TMO - 1, 1'b0);
        fix_dq = 1'b0;
        // reset in the middle of a write
        wr_req = 1'b1;
        run(4, -1, 1'b0);
        rst = 1'b1;
        run(1, -1, 1'b0);
        rst = 1'b0; wr_req = 1'b0;
        run(3, -1, 1'b0);
        // random traffic
        run(4000, -1, 1'b1);
        rst = 1'b0;
        run(4, -1, 1'b0);
        @(negedge clk); #1;
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
